irq_nest_ctrl: RTL and testbench
================================

// Module: irq_nest_ctrl
// PURPOSE
// - Prioritised, nesting interrupt controller for the 5-stage pipeline; replaces the single-IE scheme.
// - Latches edge-triggered requests and picks the highest-priority pending line.
// - Decides when EX may be redirected to a vector, and keeps a return-PC stack so a higher-priority IRQ can preempt a running handler.
// - Sits beside the EX-stage redirect mux: its take/ret outputs feed nextPC selection and the pipeline flush (bubble).
// PARAMETERS
// - NUM_IRQ    8      number of request lines; index 0 = highest priority
// - DEPTH      4      maximum nesting depth (context stack entries), >=1
// - VEC_BASE   32'h0  vector base; vector of line i = VEC_BASE + ((i+1)<<2)
// PORTS
// - clk         in   1        clock, rising edge
// - rst         in   1        synchronous reset, active-high
// - irq_req     in   NUM_IRQ  raw level request lines, synchronous to clk
// - irq_mask    in   NUM_IRQ  1 = line enabled for taking; masked lines still latch pending
// - ex_valid    in   1        EX holds a real instruction (not NOP/bubble); taking allowed only when 1
// - ex_ret      in   1        EX holds URET
// - resume_pc   in   32       PC to resume after the EX instruction (realPC if jump, else EX.PC+4)
// - take        out  1        combinational: redirect fetch to vec_addr this cycle
// - vec_addr    out  32       vector of the line being taken (valid while take=1, else 0)
// - ret_go      out  1        combinational: URET accepted, redirect fetch to epc
// - epc         out  32       return PC at top of stack (0 when stack empty)
// - pending     out  NUM_IRQ  latched pending bits
// - level       out  $clog2(DEPTH+1)  current nesting depth
// - cur_id      out  $clog2(NUM_IRQ)  id of the active handler (top of stack), 0 when level=0
// - err         out  1        sticky: URET with empty stack
// BEHAVIOUR
// - Reset: pending=0, level=0, stack cleared, err=0; all outputs 0; edge-detect history=0.
// - Edge detect: pending[i] sets on the cycle after a 0->1 edge of irq_req[i] (1-cycle latency). Held-high lines set pending once only.
// - Candidate: lowest index i with pending[i] & irq_mask[i].
// - take=1 iff all of: a candidate exists; ex_valid; !ex_ret; level<DEPTH; and (level==0 or candidate index < cur_id), i.e. strictly higher priority than the active handler.
// - On take (clock edge): push {id,resume_pc}; level++; clear pending[id].
//   - Same-cycle new edge on the same line: set wins, so pending stays 1.
// - ret_go = ex_ret & level>0. On ret_go: pop; level--; epc/cur_id then show the new top.
// - ex_ret with level==0: ret_go=0, err<=1 (sticky until rst), no state change.
// - take and ret in the same cycle cannot happen, because take is gated by !ex_ret. A candidate blocked this way is taken on the next eligible cycle.
// - Equal or lower priority than the active handler: stays pending; taken once it is top-ranked after the pops.
// - level==DEPTH: no take; pending retained.
// - Mask clear while pending: the line is not taken, but its pending bit is retained.
// - rst mid-handler: the stack is discarded immediately, with no pop side effects.
// - All stack storage is registered; take, vec_addr, ret_go and epc are combinational from regs and inputs (zero-cycle redirect in EX).
// STRUCTURE
// - Shared package:
//   - typedef struct packed {logic [IDW-1:0] id; logic [31:0] pc;} irq_ctx_t;
//   - IRQ_VEC_STRIDE = 4.
// - Sub-module irq_ctx_stack:
//   - DEPTH-entry LIFO of irq_ctx_t with push, pop, top, count.
//   - Push while full, or pop while empty, is ignored internally.
// - Top level holds the edge detect, pending regs, priority encoder, take/ret logic and err.
// TESTING
// - Single IRQ:
//   - Stimulus: rise irq_req[3] at cycle 10, mask=FF, ex_valid=1, resume_pc=0x40.
//   - Required: pending[3]=1 at cycle 11 and take=1 at cycle 11, vec_addr=0x10.
//   - Next cycle: level=1, cur_id=3, epc=0x40, pending[3]=0.
// - Nesting:
//   - Stimulus: while in id 3 (resume 0x40), rise irq_req[1] with resume_pc=0x200.
//   - Required: take with vec_addr=0x08, level=2, epc=0x200.
//   - Then URET gives ret_go=1, epc=0x40, level=1; a second URET gives level=0.
// - No preemption:
//   - Stimulus: in id 1, rise irq_req[5].
//   - Required: pending[5] held, take=0.
//   - After URET: take fires for id 5 (vec 0x18) once ex_valid=1.
// - Gating:
//   - Stimulus: pending id 2 with ex_valid=0 for 3 cycles, then ex_ret=1 for 1 cycle, then ex_valid=1.
//   - Required: take=0 throughout, then 1 in the first cycle with ex_valid=1 & !ex_ret.
// - Depth limit and errors:
//   - DEPTH=2, level=2 with ids 6 then 4; rise irq_req[0] -> take=0 until a pop.
//   - URET at level 0 -> err=1, level stays 0.
//   - rst mid-handler -> all outputs 0 next cycle.
// - Edge and race:
//   - Hold irq_req[7] high 20 cycles -> exactly one take.
//   - New edge on line 2 in its take cycle -> pending[2]=1 after the take.

Source files
------------

// File: rtl/irq_nest_ctrl_pkg.sv
// Shared types and constants for the nesting interrupt controller.
// The saved context pairs the handler id with the PC to resume at.
package irq_nest_ctrl_pkg;

  localparam int IRQ_NUM_MAX    = 8;
  localparam int IDW            = $clog2(IRQ_NUM_MAX);
  localparam int IRQ_VEC_STRIDE = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    pc;
  } irq_ctx_t;

  // Line i vectors to base + (i+1)*stride; slot 0 is left to the reset vector.
  function automatic logic [31:0] irq_vec(input logic [31:0]    base,
                                          input logic [IDW-1:0] id);
    return base + ((32'(id) + 32'd1) * 32'(IRQ_VEC_STRIDE));
  endfunction

endpackage

// File: rtl/irq_nest_ctrl_ctx_stack.sv
// LIFO of saved interrupt contexts. The top entry is exposed combinationally;
// a push while full or a pop while empty is silently dropped.
module irq_nest_ctrl_ctx_stack
  import irq_nest_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  irq_ctx_t      push_ctx_i,
  output irq_ctx_t      top_o,
  output logic [CW-1:0] count_o
);

  irq_ctx_t      ctx_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0) && !push_i;

  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok)     cnt_d = cnt_q + CW'(1);
    else if (pop_ok) cnt_d = cnt_q - CW'(1);
  end

  // NOTE: the storage array is reset explicitly, so a discarded stack never leaks old PCs through top_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ctx_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        if (push_ok && cnt_q == CW'(i)) ctx_q[i] <= push_ctx_i;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (cnt_q == CW'(i + 1)) top_o = ctx_q[i];
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/irq_nest_ctrl.sv
// Prioritised, nesting interrupt controller beside the EX redirect mux.
// take/ret_go are combinational so EX can redirect fetch in the same cycle.
module irq_nest_ctrl
  import irq_nest_ctrl_pkg::*;
#(
  parameter  int          NUM_IRQ  = 8,
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] VEC_BASE = 32'h0,
  localparam int          LW       = $clog2(DEPTH + 1),
  localparam int          CIW      = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               ex_valid_i,
  input  logic               ex_ret_i,
  input  logic [31:0]        resume_pc_i,
  output logic               take_o,
  output logic [31:0]        vec_addr_o,
  output logic               ret_go_o,
  output logic [31:0]        epc_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [LW-1:0]      level_o,
  output logic [CIW-1:0]     cur_id_o,
  output logic               err_o
);

  logic [NUM_IRQ-1:0] req_q, pend_q, pend_d, rise, clr;
  logic               err_q, err_d;
  logic               cand_vld, prio_ok;
  logic [IDW-1:0]     cand;
  irq_ctx_t           top, push_ctx;
  logic [LW-1:0]      level;

  irq_nest_ctrl_ctx_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push_i    (take_o),
    .pop_i     (ret_go_o),
    .push_ctx_i(push_ctx),
    .top_o     (top),
    .count_o   (level)
  );

  assign rise = irq_req_i & ~req_q;

  // Scan from the lowest-priority end so the last hit is the lowest index.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i] && irq_mask_i[i]) begin
        cand_vld = 1'b1;
        cand     = IDW'(i);
      end
    end
  end

  assign prio_ok  = (level == '0) || (cand < top.id);
  assign take_o   = cand_vld && ex_valid_i && !ex_ret_i &&
                    (level < LW'(DEPTH)) && prio_ok;
  assign vec_addr_o = take_o ? irq_vec(VEC_BASE, cand) : 32'h0;
  assign ret_go_o = ex_ret_i && (level != '0);
  assign push_ctx = '{id: cand, pc: resume_pc_i};

  // A fresh edge in the take cycle re-arms the line, hence rise is OR'd last.
  assign clr    = take_o ? (NUM_IRQ'(1) << cand) : '0;
  assign pend_d = (pend_q & ~clr) | rise;
  assign err_d  = err_q || (ex_ret_i && level == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      req_q  <= irq_req_i;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign epc_o     = top.pc;
  assign cur_id_o  = top.id[CIW-1:0];
  assign level_o   = level;
  assign pending_o = pend_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Directed bench for irq_nest_ctrl with a two-deep stack so the depth
// limit is reachable; expected values are hand-derived per step.
module tb_irq_nest_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_req, irq_mask, pending;
  logic        ex_valid, ex_ret, take, ret_go, err;
  logic [31:0] resume_pc, vec_addr, epc;
  logic [1:0]  level;
  logic [2:0]  cur_id;

  int n_tests = 0;
  int n_fail  = 0;
  int takes;

  irq_nest_ctrl #(.NUM_IRQ(8), .DEPTH(2), .VEC_BASE(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_req_i  (irq_req),
    .irq_mask_i (irq_mask),
    .ex_valid_i (ex_valid),
    .ex_ret_i   (ex_ret),
    .resume_pc_i(resume_pc),
    .take_o     (take),
    .vec_addr_o (vec_addr),
    .ret_go_o   (ret_go),
    .epc_o      (epc),
    .pending_o  (pending),
    .level_o    (level),
    .cur_id_o   (cur_id),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_take"},    32'(take),     32'h0);
    chk({tag, "_vec"},     vec_addr,      32'h0);
    chk({tag, "_ret_go"},  32'(ret_go),   32'h0);
    chk({tag, "_epc"},     epc,           32'h0);
    chk({tag, "_pending"}, 32'(pending),  32'h0);
    chk({tag, "_level"},   32'(level),    32'h0);
    chk({tag, "_cur_id"},  32'(cur_id),   32'h0);
    chk({tag, "_err"},     32'(err),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; irq_req = '0; irq_mask = 8'hFF;
    ex_valid = 1'b0; ex_ret = 1'b0; resume_pc = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1 chk_idle("reset");

    // Single IRQ on line 3
    ex_valid = 1'b1; resume_pc = 32'h40; irq_req = 8'h08;
    #1 chk("single_pre_take", 32'(take), 32'h0);
    tick();
    chk("single_pending", 32'(pending), 32'h08);
    chk("single_take",    32'(take),    32'h1);
    chk("single_vec",     vec_addr,     32'h10);
    irq_req = '0;
    tick();
    chk("single_level",   32'(level),   32'h1);
    chk("single_cur_id",  32'(cur_id),  32'h3);
    chk("single_epc",     epc,          32'h40);
    chk("single_cleared", 32'(pending), 32'h0);
    chk("single_no_take", 32'(take),    32'h0);

    // Nest line 1 on top of line 3, then unwind
    resume_pc = 32'h200; irq_req = 8'h02;
    tick();
    chk("nest_take", 32'(take), 32'h1);
    chk("nest_vec",  vec_addr,  32'h08);
    irq_req = '0;
    tick();
    chk("nest_level",  32'(level),  32'h2);
    chk("nest_epc",    epc,         32'h200);
    chk("nest_cur_id", 32'(cur_id), 32'h1);
    ex_ret = 1'b1;
    #1 chk("uret1_go",   32'(ret_go), 32'h1);
    chk("uret1_no_take", 32'(take),   32'h0);
    tick();
    chk("uret1_level",  32'(level),  32'h1);
    chk("uret1_epc",    epc,         32'h40);
    chk("uret1_cur_id", 32'(cur_id), 32'h3);
    chk("uret2_go",     32'(ret_go), 32'h1);
    tick();
    ex_ret = 1'b0;
    #1 chk("uret2_level", 32'(level), 32'h0);
    chk("uret2_epc", epc,      32'h0);
    chk("uret2_err", 32'(err), 32'h0);

    // Line 5 may not preempt handler 1
    irq_req = 8'h02;
    tick();
    chk("np_take1", 32'(take), 32'h1);
    resume_pc = 32'h80; irq_req = '0;
    tick();
    chk("np_level1", 32'(level),  32'h1);
    chk("np_cur1",   32'(cur_id), 32'h1);
    chk("np_epc1",   epc,         32'h80);
    irq_req = 8'h20;
    tick();
    chk("np_pending5", 32'(pending), 32'h20);
    chk("np_blocked",  32'(take),    32'h0);
    irq_req = '0;
    tick();
    chk("np_held",     32'(pending), 32'h20);
    chk("np_blocked2", 32'(take),    32'h0);
    ex_ret = 1'b1;
    #1 chk("np_ret_go",  32'(ret_go), 32'h1);
    chk("np_ret_no_take", 32'(take),  32'h0);
    tick();
    ex_ret = 1'b0; ex_valid = 1'b0;
    #1 chk("np_level0", 32'(level), 32'h0);
    chk("np_no_valid", 32'(take), 32'h0);
    ex_valid = 1'b1;
    #1 chk("np_take5", 32'(take), 32'h1);
    chk("np_vec5", vec_addr, 32'h18);
    resume_pc = 32'h100;
    tick();
    chk("np_cur5", 32'(cur_id), 32'h5);
    chk("np_epc5", epc,         32'h100);

    // Gating: line 2 pending inside handler 5
    ex_valid = 1'b0; irq_req = 8'h04;
    tick();
    irq_req = '0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("gate_no_valid", 32'(take), 32'h0);
      tick();
    end
    ex_ret = 1'b1; ex_valid = 1'b1;
    #1 chk("gate_ret_blocks", 32'(take), 32'h0);
    chk("gate_ret_go", 32'(ret_go), 32'h1);
    tick();
    ex_ret = 1'b0;
    #1 chk("gate_take", 32'(take), 32'h1);
    chk("gate_vec", vec_addr, 32'h0C);
    chk("gate_err", 32'(err), 32'h0);

    // New edge on line 2 during its own take cycle
    irq_req = 8'h04; resume_pc = 32'h300;
    tick();
    chk("race_level",   32'(level),   32'h1);
    chk("race_cur_id",  32'(cur_id),  32'h2);
    chk("race_epc",     epc,          32'h300);
    chk("race_pending", 32'(pending), 32'h04);
    chk("race_eq_prio", 32'(take),    32'h0);
    irq_req = '0; ex_ret = 1'b1;
    tick();
    ex_ret = 1'b0;
    #1 chk("race_retake", 32'(take), 32'h1);
    tick();
    chk("race_cleared", 32'(pending), 32'h0);
    ex_ret = 1'b1;
    tick();
    ex_ret = 1'b0;
    #1 chk("race_level0", 32'(level), 32'h0);

    // Depth limit: ids 6 then 4 fill the stack
    irq_req = 8'h40;
    tick();
    chk("depth_vec6", vec_addr, 32'h1C);
    resume_pc = 32'h600; irq_req = '0;
    tick();
    irq_req = 8'h10;
    tick();
    chk("depth_vec4", vec_addr, 32'h14);
    resume_pc = 32'h400; irq_req = '0;
    tick();
    chk("depth_level2", 32'(level),  32'h2);
    chk("depth_cur4",   32'(cur_id), 32'h4);
    chk("depth_epc4",   epc,         32'h400);
    irq_req = 8'h01;
    tick();
    chk("depth_pending0", 32'(pending), 32'h01);
    chk("depth_full",     32'(take),    32'h0);
    irq_req = '0;
    tick();
    chk("depth_full2",  32'(take),    32'h0);
    chk("depth_retain", 32'(pending), 32'h01);
    ex_ret = 1'b1;
    #1 chk("depth_ret_go", 32'(ret_go), 32'h1);
    chk("depth_ret_no_take", 32'(take), 32'h0);
    tick();
    ex_ret = 1'b0; resume_pc = 32'h500;
    #1 chk("depth_pop_cur6", 32'(cur_id), 32'h6);
    chk("depth_pop_epc", epc,        32'h600);
    chk("depth_take0",   32'(take),  32'h1);
    chk("depth_vec0",    vec_addr,   32'h04);
    tick();
    chk("depth_level_again", 32'(level), 32'h2);
    chk("depth_cur0",        32'(cur_id), 32'h0);
    chk("depth_epc0",        epc,         32'h500);
    ex_ret = 1'b1;
    repeat (2) tick();
    ex_ret = 1'b0;
    #1 chk("depth_unwound", 32'(level), 32'h0);

    // Masked line keeps its pending bit
    irq_mask = 8'hF7; irq_req = 8'h08;
    tick();
    chk("mask_pending", 32'(pending), 32'h08);
    chk("mask_no_take", 32'(take),    32'h0);
    irq_req = '0;
    tick();
    chk("mask_retain", 32'(pending), 32'h08);
    irq_mask = 8'hFF;
    #1 chk("mask_take", 32'(take), 32'h1);
    chk("mask_vec", vec_addr, 32'h10);
    tick();
    ex_ret = 1'b1;
    tick();
    ex_ret = 1'b0;

    // URET with an empty stack
    ex_ret = 1'b1;
    #1 chk("err_no_ret_go", 32'(ret_go), 32'h0);
    tick();
    ex_ret = 1'b0;
    #1 chk("err_set",   32'(err),   32'h1);
    chk("err_level", 32'(level), 32'h0);

    // Held-high line produces one take only
    irq_req = 8'h80; takes = 0;
    for (int k = 0; k < 20; k++) begin
      #1 if (take) takes++;
      tick();
    end
    chk("held_takes", 32'(takes),  32'h1);
    chk("held_cur7",  32'(cur_id), 32'h7);
    irq_req = '0;

    // Reset in the middle of a handler
    ex_valid = 1'b0; irq_req = 8'h10;
    tick();
    irq_req = '0;
    chk("pre_rst_pending", 32'(pending), 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk_idle("mid_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
